// File: rtl/cache_axi_refill.sv
// Cache miss refill engine: optional dirty-line write-back, then an INCR burst read of the missing line.
// Optional AXI_RESP_CHECK_EN build adds a sticky bus_err flag for bad responses and rlast misplacement.
`timescale 1ns/1ps
module cache_axi_refill #(
  parameter int         CACHELINE_WD = 512,
  parameter logic [3:0] ID           = 4'd0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    miss,
  input  logic [31:0]             raddr,
  input  logic                    write_back,
  input  logic [31:0]             waddr,
  input  logic [CACHELINE_WD-1:0] cacheline_old,
  output logic                    refresh,
  output logic [CACHELINE_WD-1:0] cacheline_new,
  output logic                    busy,
  output logic                    bus_err,
  output logic [3:0]              arid,
  output logic [31:0]             araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [3:0]              rid,
  input  logic [31:0]             rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  output logic [3:0]              awid,
  output logic [31:0]             awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [31:0]             wdata,
  output logic [3:0]              wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [3:0]              bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  localparam int            N    = CACHELINE_WD / 32;
  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam int            OFF  = $clog2(CACHELINE_WD / 8);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE, S_HOLD} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [31:0]             raddr_q, raddr_d;
  logic [31:0]             waddr_q, waddr_d;
  logic [CACHELINE_WD-1:0] wbuf_q, wbuf_d;
  logic [CACHELINE_WD-1:0] rbuf_q, rbuf_d;
  logic [CW+4:0]           widx;
  logic                    unused_ok;

  assign widx = {cnt_q, 5'd0};

`ifdef AXI_RESP_CHECK_EN
  logic bus_err_q, bus_err_d;
  assign bus_err   = bus_err_q;
  assign unused_ok = ^{rid, bid, raddr[OFF-1:0], waddr[OFF-1:0]};
`else
  assign bus_err   = 1'b0;
  assign unused_ok = ^{rid, bid, raddr[OFF-1:0], waddr[OFF-1:0], rresp, bresp, rlast};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    raddr_d = raddr_q;
    waddr_d = waddr_q;
    wbuf_d  = wbuf_q;
    rbuf_d  = rbuf_q;
`ifdef AXI_RESP_CHECK_EN
    bus_err_d = bus_err_q;
`endif
    case (state_q)
      S_IDLE: if (miss) begin
        raddr_d = {raddr[31:OFF], {OFF{1'b0}}};
        waddr_d = {waddr[31:OFF], {OFF{1'b0}}};
        wbuf_d  = cacheline_old;
        cnt_d   = '0;
        state_d = write_back ? S_AW : S_AR;
      end
      S_AW: if (awready) state_d = S_W;
      S_W: if (wready) begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_B;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_B: if (bvalid) begin
        state_d = S_AR;
`ifdef AXI_RESP_CHECK_EN
        if (bresp != 2'b00) bus_err_d = 1'b1;
`endif
      end
      S_AR: if (arready) state_d = S_R;
      // Beat count, not rlast, terminates the burst.
      S_R: if (rvalid) begin
        rbuf_d[widx +: 32] = rdata;
`ifdef AXI_RESP_CHECK_EN
        if (rresp != 2'b00 || rlast != (cnt_q == LAST)) bus_err_d = 1'b1;
`endif
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_HOLD;
      S_HOLD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      raddr_q <= '0;
      waddr_q <= '0;
      wbuf_q  <= '0;
      rbuf_q  <= '0;
`ifdef AXI_RESP_CHECK_EN
      bus_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      raddr_q <= raddr_d;
      waddr_q <= waddr_d;
      wbuf_q  <= wbuf_d;
      rbuf_q  <= rbuf_d;
`ifdef AXI_RESP_CHECK_EN
      bus_err_q <= bus_err_d;
`endif
    end
  end

  // Handshake outputs decode directly from the state register.
  assign awvalid       = (state_q == S_AW);
  assign wvalid        = (state_q == S_W);
  assign bready        = (state_q == S_B);
  assign arvalid       = (state_q == S_AR);
  assign rready        = (state_q == S_R);
  assign refresh       = (state_q == S_DONE);
  assign busy          = (state_q != S_IDLE);
  assign wlast         = wvalid && (cnt_q == LAST);
  assign wstrb         = wvalid ? 4'hF : 4'h0;
  assign wdata         = wbuf_q[widx +: 32];
  assign cacheline_new = rbuf_q;
  assign araddr        = raddr_q;
  assign awaddr        = waddr_q;
  assign arid          = ID;
  assign awid          = ID;
  assign arlen         = 8'(N - 1);
  assign awlen         = 8'(N - 1);
  assign arsize        = 3'b010;
  assign awsize        = 3'b010;
  assign arburst       = 2'b01;
  assign awburst       = 2'b01;

endmodule

// File: tb/tb_cache_axi_refill.sv
// Directed bench for cache_axi_refill: the initial block plays both the cache and the AXI slave.
`timescale 1ns/1ps
module tb_cache_axi_refill;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst, miss, write_back;
  logic [31:0]  raddr, waddr;
  logic [511:0] cacheline_old, cacheline_new;
  logic         refresh, busy, bus_err;
  logic [3:0]   arid, awid, rid, bid;
  logic [31:0]  araddr, awaddr, rdata, wdata;
  logic [7:0]   arlen, awlen;
  logic [2:0]   arsize, awsize;
  logic [1:0]   arburst, awburst, rresp, bresp;
  logic         arvalid, arready, rlast, rvalid, rready;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]   wstrb;

  int passes = 0;
  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int miss_cyc;
  int lat;
  logic exp_err;
  logic [511:0] line;

  cache_axi_refill dut (
    .clk(clk), .rst(rst), .miss(miss), .raddr(raddr), .write_back(write_back),
    .waddr(waddr), .cacheline_old(cacheline_old), .refresh(refresh),
    .cacheline_new(cacheline_new), .busy(busy), .bus_err(bus_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycles=%0d required <100000", cyc);
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_line(input string tag, input logic [31:0] base);
    for (int i = 0; i < N; i++)
      check($sformatf("%s_w%0d", tag, i), cacheline_new[32*i +: 32], base + i);
  endtask

  task automatic serve_write(input logic [31:0] exp_addr, input logic [511:0] old, input int gaps);
    int k = 0;
    int d;
    while (!awvalid && k < 100) begin tick(); k++; end
    check("aw_seen", awvalid, 1);
    if (!awvalid) return;
    check("awaddr", awaddr, exp_addr);
    check("aw_fields", {awid, awlen, awsize, awburst}, {4'd0, 8'd15, 3'b010, 2'b01});
    d = (gaps > 0) ? $urandom_range(0, gaps) : 0;
    repeat (d) begin tick(); check("aw_hold", {awvalid, awaddr}, {1'b1, exp_addr}); end
    awready = 1'b1; tick(); awready = 1'b0;
    for (int i = 0; i < N; i++) begin
      check($sformatf("w_beat%0d", i), {wvalid, wlast, wstrb, wdata},
            {1'b1, (i == N-1), 4'hF, old[32*i +: 32]});
      d = (gaps > 0) ? $urandom_range(0, gaps) : 0;
      repeat (d) begin
        tick();
        check("w_hold", {wvalid, wlast, wdata}, {1'b1, (i == N-1), old[32*i +: 32]});
      end
      wready = 1'b1; tick(); wready = 1'b0;
    end
    check("b_wait", {bready, arvalid, wvalid}, 3'b100);
    d = (gaps > 0) ? $urandom_range(1, gaps) : 0;
    repeat (d) begin tick(); check("b_hold", {bready, arvalid}, 2'b10); end
    bvalid = 1'b1; bresp = 2'b00; tick(); bvalid = 1'b0;
  endtask

  task automatic serve_read(input logic [31:0] exp_addr, input logic [31:0] base,
                            input int gaps, input int err_beat, output int l);
    int k = 0;
    int d;
    l = -1;
    while (!arvalid && k < 100) begin tick(); k++; end
    check("ar_seen", arvalid, 1);
    if (!arvalid) return;
    check("araddr", araddr, exp_addr);
    check("ar_fields", {arid, arlen, arsize, arburst}, {4'd0, 8'd15, 3'b010, 2'b01});
    d = (gaps > 0) ? $urandom_range(0, gaps) : 0;
    repeat (d) begin tick(); check("ar_hold", {arvalid, araddr}, {1'b1, exp_addr}); end
    arready = 1'b1; tick(); arready = 1'b0;
    for (int i = 0; i < N; i++) begin
      d = (gaps > 0) ? $urandom_range(0, gaps) : 0;
      rvalid = 1'b0;
      repeat (d) tick();
      check("r_ready", {rready, refresh}, 2'b10);
      rvalid = 1'b1;
      rdata  = base + i;
      rresp  = (i == err_beat) ? 2'b10 : 2'b00;
      rlast  = (i == N-1);
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    check("refresh", {refresh, busy, rready}, 3'b110);
    l = cyc - miss_cyc;
  endtask

  initial begin
    rst = 1'b1; miss = 1'b0; write_back = 1'b0; raddr = '0; waddr = '0; cacheline_old = '0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
`ifdef AXI_RESP_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    repeat (3) tick();

    check("rst_ctrl", {arvalid, awvalid, wvalid, rready, bready, refresh, busy, bus_err}, 8'h00);
    check("rst_addr", {araddr, awaddr}, 64'h0);
    check("rst_wbus", {wdata, wstrb, wlast}, 37'h0);
    check("rst_line", |cacheline_new, 1'b0);
    rst = 1'b0;
    tick();

    // Clean refill, zero wait states.
    miss = 1'b1; write_back = 1'b0; raddr = 32'h1000_0044; miss_cyc = cyc;
    serve_read(32'h1000_0040, 32'hA000_0000, 0, -1, lat);
    check("clean_latency", lat, 18);
    check("clean_w0", cacheline_new[31:0], 32'hA000_0000);
    check("clean_w15", cacheline_new[511:480], 32'hA000_000F);
    check_line("clean", 32'hA000_0000);
    miss = 1'b0;
    tick();
    check("hold_state", {refresh, busy, arvalid}, 3'b010);
    tick();
    check("idle_state", {refresh, busy, arvalid, bus_err}, 4'b0000);
    check("line_stable", cacheline_new[511:480], 32'hA000_000F);

    // Write-back then refill, zero wait states.
    for (int i = 0; i < N; i++) line[32*i +: 32] = i;
    miss = 1'b1; write_back = 1'b1; waddr = 32'h2000_007C; raddr = 32'h3000_0000;
    cacheline_old = line; miss_cyc = cyc;
    serve_write(32'h2000_0040, line, 0);
    serve_read(32'h3000_0000, 32'hB000_0000, 0, -1, lat);
    check("wb_latency", lat, 36);
    check_line("wb", 32'hB000_0000);
    miss = 1'b0; write_back = 1'b0; cacheline_old = '0;
    repeat (2) tick();

    // Backpressure on every channel.
    for (int i = 0; i < N; i++) line[32*i +: 32] = 32'h5A00_0000 | i;
    miss = 1'b1; write_back = 1'b1; waddr = 32'h0000_1234; raddr = 32'h4000_00FF;
    cacheline_old = line; miss_cyc = cyc;
    serve_write(32'h0000_1200, line, 3);
    serve_read(32'h4000_00C0, 32'hD000_0000, 3, -1, lat);
    check_line("bp", 32'hD000_0000);
    miss = 1'b0; write_back = 1'b0;
    repeat (2) tick();

    // Miss held through refresh: HOLD must not start a new read.
    miss = 1'b1; raddr = 32'h5000_0010; miss_cyc = cyc;
    serve_read(32'h5000_0000, 32'hE000_0000, 0, -1, lat);
    tick();
    check("b2b_hold", {arvalid, busy, refresh}, 3'b010);
    tick();
    check("b2b_idle", {arvalid, busy}, 2'b00);
    tick();
    check("b2b_ar", arvalid, 1'b1);
    serve_read(32'h5000_0000, 32'hE100_0000, 0, -1, lat);
    check_line("b2b", 32'hE100_0000);
    miss = 1'b0;
    repeat (2) tick();

    // Reset asserted while beat 7 of the read is on the bus.
    miss = 1'b1; raddr = 32'h6000_0000;
    tick();
    check("rr_ar", arvalid, 1'b1);
    arready = 1'b1; tick(); arready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rvalid = 1'b1; rdata = 32'hF000_0000 + i; tick();
    end
    rdata = 32'hF000_0007;
    rst = 1'b1;
    #1;
    check("rr_outs", {arvalid, awvalid, wvalid, rready, bready, refresh, busy}, 7'h00);
    check("rr_line", cacheline_new[31:0], 32'h0);
    rvalid = 1'b0; miss = 1'b0;
    tick();
    rst = 1'b0;
    begin
      logic seen = 1'b0;
      repeat (4) begin tick(); seen = seen | refresh | busy; end
      check("rr_quiet", seen, 1'b0);
    end
    miss = 1'b1; raddr = 32'h6000_0000; miss_cyc = cyc;
    serve_read(32'h6000_0000, 32'h7000_0000, 2, -1, lat);
    check_line("rr_after", 32'h7000_0000);
    miss = 1'b0;
    repeat (2) tick();

    // Error response on beat 3.
    check("err_before", bus_err, 1'b0);
    miss = 1'b1; raddr = 32'h0800_0000; miss_cyc = cyc;
    serve_read(32'h0800_0000, 32'h1100_0000, 0, 3, lat);
    check("err_latency", lat, 18);
    check("err_flag", bus_err, exp_err);
    miss = 1'b0;
    repeat (3) tick();
    check("err_sticky", {bus_err, busy}, {exp_err, 1'b0});

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cache_axi_refill.md
# cache_axi_refill

Memory-side companion to the cache: services cache misses over an AXI4 burst master. On `miss` it optionally writes the dirty victim line back (`write_back`, `waddr`, `cacheline_old`), burst-reads the missing line at `raddr`, and returns it on `cacheline_new` with a one-cycle `refresh` pulse. It sits between the cache and the system AXI interconnect.

## Interface
- `CACHELINE_WD`, 512: line width in bits; multiple of 32; beats per line `N = CACHELINE_WD/32` (16 by default).
- `ID`, 4'd0: constant value driven on `arid` and `awid`.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `miss`  in  1  cache requests refill; held until `refresh`.
- `raddr`  in  32  refill address.
- `write_back`  in  1  victim is dirty; qualified by `miss`.
- `waddr`  in  32  victim address.
- `cacheline_old`  in  CACHELINE_WD  victim data.
- `refresh`  out  1  one-cycle pulse: `cacheline_new` valid.
- `cacheline_new`  out  CACHELINE_WD  refilled line.
- `busy`  out  1  high in every state except IDLE.
- `bus_err`  out  1  sticky error flag (see Configuration).
- `arid[3:0] araddr[31:0] arlen[7:0] arsize[2:0] arburst[1:0] arvalid`  out; `arready`  in.
- `rid[3:0] rdata[31:0] rresp[1:0] rlast rvalid`  in; `rready`  out.
- `awid[3:0] awaddr[31:0] awlen[7:0] awsize[2:0] awburst[1:0] awvalid`  out; `awready`  in.
- `wdata[31:0] wstrb[3:0] wlast wvalid`  out; `wready`  in.
- `bid[3:0] bresp[1:0] bvalid`  in; `bready`  out.

## Operation
- States: IDLE, AW, W, B, AR, R, DONE, HOLD.
- IDLE: on `miss`, capture `raddr` and `waddr` with the low `log2(CACHELINE_WD/8)` bits cleared. Capture `cacheline_old` into the write buffer and clear the beat counter. Go to AW if `write_back`, else AR.
- AW: `awvalid`=1, `awlen`=N-1, `awsize`=3'b010, `awburst`=2'b01 (INCR). On `awvalid&awready`, go to W.
- W: `wvalid`=1, `wstrb`=4'hF, `wdata` = word[cnt] (word i = bits [32i+31:32i]), `wlast` = (cnt==N-1). Each `wvalid&wready` increments cnt. Handshake with wlast clears cnt and goes to B.
- B: `bready`=1. On `bvalid`, go to AR.
- AR: `arvalid`=1, same len/size/burst fields. On `arvalid&arready`, go to R.
- R: `rready`=1. Each `rvalid` beat writes `rdata` into word[cnt] of the read buffer and increments cnt. The beat with cnt==N-1 ends the burst and goes to DONE; `rlast` is not used for termination.
- DONE: `refresh`=1 for exactly this cycle; `cacheline_new` = read buffer. Go to HOLD.
- HOLD: one cycle that ignores `miss`, letting the cache drop it. Then go to IDLE.
- `cacheline_new` is held stable from DONE until the next R beat is written.
- AXI rules: a valid, once raised, is held with its payload stable until its ready. Only one transaction is outstanding at a time. AW and W are sequential, never overlapped.

## Timing
- Reset values: all valids 0, `rready`=0, `bready`=0, `refresh`=0, `busy`=0, `bus_err`=0, `cacheline_new`=0, all address and data outputs 0, state IDLE, cnt 0.
- Reset asserted mid-burst aborts immediately to IDLE with all valids low. There is no recovery of the outstanding AXI transaction.
- `miss` sampled in IDLE at edge t gives `arvalid` or `awvalid` high from t+1.
- Zero-wait refill without write-back: `refresh` occurs 1 (AR) + N (R) + 1 cycles after the IDLE edge, which is 18 cycles for N=16.
- Write-back adds 1 (AW) + N (W) + at least 1 (B) cycles.
- `miss` is ignored in every state except IDLE. The earliest acceptance of a new miss is 2 cycles after `refresh`.
- All outputs are registered, with no combinational input-to-output paths except through state.

## Configuration
- `AXI_RESP_CHECK_EN`
- Defined:
  - `bus_err` is set when `bresp` on the B handshake, or `rresp` on any R beat, is non-zero (not OKAY).
  - `bus_err` is also set if `rlast` disagrees with cnt==N-1 on any R beat.
  - The transaction still completes normally.
  - `bus_err` is cleared only by `rst`.
- Undefined: `bresp`, `rresp` and `rlast` are ignored, and `bus_err` is tied to 0.

## Test plan
- Clean refill: `miss`=1, `write_back`=0, `raddr`=0x1000_0044; memory returns words 0..15 = 0xA000_0000+i with no wait states -> `araddr`=0x1000_0040, `arlen`=15, `refresh` one cycle at cycle 18, `cacheline_new[31:0]`=0xA000_0000, `cacheline_new[511:480]`=0xA000_000F.
- Write-back then refill: `write_back`=1, `waddr`=0x2000_007C, `cacheline_old` word i = i -> `awaddr`=0x2000_0040; wdata sequence 0..15 with `wlast` only on beat 15; `arvalid` only after `bvalid`; `refresh` after the read completes.
- Backpressure: random `awready`, `wready`, `arready` and `rvalid` gaps (0-3 cycles) -> payloads stay stable while valid is high, no beat is lost or duplicated, and `cacheline_new` matches the memory model.
- Reset mid-R at beat 7 -> next cycle all valids and ready outputs are 0, state is IDLE, `busy`=0, and no `refresh` occurs; a following `miss` completes normally.
- Back-to-back misses: `miss` held high through `refresh` -> no second `arvalid` during HOLD; a new AR is issued only if `miss` is still high in IDLE.
- With `AXI_RESP_CHECK_EN`: `rresp`=2'b10 on beat 3 -> `bus_err` rises and stays 1, and `refresh` still pulses. Without the macro -> `bus_err` stays 0.
